// File: rtl/params_pkg.sv
// Shared type definitions for the systolic array datapath.
// full_type_t: encoding of the operand/accumulator data type handed to the PEs.
package params;

    typedef logic [3:0] full_type_t;

endpackage

// File: rtl/systolic_seq_if.sv
// Command, preload, array-control and drain signals of the tile sequencer.
// Names carry the sequencer's direction: i_* flow into systolic_seq, o_* flow out.
//   master : command/AXI front end side (drives i_*, observes o_*)
//   slave  : systolic_seq side
interface systolic_seq_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned KMAX = 256
);
    logic                        i_start_valid;
    logic                        o_start_ready;
    logic [$clog2(KMAX+1)-1:0]   i_k_len;
    params::full_type_t          i_compute_type;
    logic                        i_c_valid;
    logic                        o_c_ready;
    logic                        o_we;
    logic                        o_en;
    logic                        o_cm;
    params::full_type_t          o_compute_type_out;
    logic                        o_out_valid;
    logic                        i_out_ready;
    logic [$clog2(N)-1:0]        o_out_row;
    logic                        o_busy;
    logic                        o_done;
    logic [31:0]                 o_perf_cycles;

    modport master (
        output i_start_valid, i_k_len, i_compute_type, i_c_valid, i_out_ready,
        input  o_start_ready, o_c_ready, o_we, o_en, o_cm, o_compute_type_out,
               o_out_valid, o_out_row, o_busy, o_done, o_perf_cycles
    );

    modport slave (
        input  i_start_valid, i_k_len, i_compute_type, i_c_valid, i_out_ready,
        output o_start_ready, o_c_ready, o_we, o_en, o_cm, o_compute_type_out,
               o_out_valid, o_out_row, o_busy, o_done, o_perf_cycles
    );

endinterface

// File: rtl/systolic_seq.sv
// Tile sequencer for an N x N PE systolic array. One matrix-multiply command at a time:
// accumulator preload (we), wavefront injection (en), skew flush, then compute-mode
// trigger (cm) and row drain under out_ready backpressure, ending in a one-cycle done.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : systolic_seq_if.slave - start handshake (k_len, compute_type), preload
//          handshake (c_valid/c_ready/we), array controls (en, cm, compute_type_out),
//          drain handshake (out_valid/out_ready/out_row), status (busy, done, perf_cycles)
//
// Optional feature: define SEQ_PERF_CNT_EN to enable the per-command cycle counter on
// perf_cycles. Without it perf_cycles is constant 0.
module systolic_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned KMAX  = 256,
    parameter int unsigned CLOAD = 4
) (
    input logic            clk,
    input logic            rst,
    systolic_seq_if.slave  bus
);

    localparam int unsigned KW       = $clog2(KMAX + 1);
    localparam int unsigned RowW     = $clog2(N);
    // 2N-2 cycles of skew plus the PE output register.
    localparam int unsigned FlushLen = 2 * N - 1;
    localparam int unsigned CntMaxA  = (KMAX > FlushLen) ? KMAX : FlushLen;
    localparam int unsigned CntMax   = (CntMaxA > CLOAD) ? CntMaxA : CLOAD;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadc,
        StFeed,
        StFlush,
        StDrain,
        StDone
    } state_e;

    state_e             r_state, w_state_next;
    logic [CntW-1:0]    r_cnt, w_cnt_next;
    logic [RowW-1:0]    r_row, w_row_next;
    logic               r_cm, w_cm_next;
    logic [KW-1:0]      r_k;
    params::full_type_t r_ctype;

    logic               w_start_ready;
    logic               w_start;
    logic               w_we;
    logic               w_out_acc;
    logic [CntW-1:0]    w_k_last;

    // Gated with rst so no command is offered or taken during the reset cycle.
    assign w_start_ready = (r_state == StIdle) && !rst;
    assign w_start       = bus.i_start_valid && w_start_ready;
    assign w_we          = bus.i_c_valid && (r_state == StLoadc);
    assign w_out_acc     = bus.i_out_ready && (r_state == StDrain);
    // FEED is only entered with k_len >= 1, so this never underflows in use.
    assign w_k_last      = CntW'(r_k) - CntW'(1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_row_next   = r_row;
        w_cm_next    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_cnt_next   = '0;
                    w_state_next = (bus.i_k_len == '0) ? StDone : StLoadc;
                end
            end
            StLoadc: begin
                if (w_we) begin
                    if (r_cnt == CntW'(CLOAD - 1)) begin
                        w_state_next = StFeed;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CntW'(1);
                    end
                end
            end
            StFeed: begin
                if (r_cnt == w_k_last) begin
                    w_state_next = StFlush;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StFlush: begin
                if (r_cnt == CntW'(FlushLen - 1)) begin
                    w_state_next = StDrain;
                    w_cnt_next   = '0;
                    // Registered so cm is high in the first DRAIN cycle only.
                    w_cm_next    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StDrain: begin
                if (w_out_acc) begin
                    if (r_row == RowW'(N - 1)) begin
                        w_state_next = StDone;
                        w_row_next   = '0;
                    end else begin
                        w_row_next = r_row + RowW'(1);
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_row   <= '0;
            r_cm    <= 1'b0;
            r_k     <= '0;
            r_ctype <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
            r_cm    <= w_cm_next;
            if (w_start) begin
                r_k     <= bus.i_k_len;
                r_ctype <= bus.i_compute_type;
            end
        end
    end

    assign bus.o_start_ready      = w_start_ready;
    assign bus.o_c_ready          = (r_state == StLoadc);
    assign bus.o_we               = w_we;
    assign bus.o_en               = (r_state == StFeed);
    assign bus.o_cm               = r_cm;
    assign bus.o_compute_type_out = r_ctype;
    assign bus.o_out_valid        = (r_state == StDrain);
    assign bus.o_out_row          = r_row;
    assign bus.o_busy             = (r_state != StIdle);
    assign bus.o_done             = (r_state == StDone);

`ifdef SEQ_PERF_CNT_EN
    // r_cyc holds the number of command cycles so far including the current one;
    // r_perf is loaded on entry to DONE so it already covers the DONE cycle.
    logic [31:0] r_cyc;
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc  <= '0;
            r_perf <= '0;
        end else begin
            if (w_start) begin
                r_cyc <= 32'd1;
            end else if ((r_state inside {StLoadc, StFeed, StFlush, StDrain}) &&
                         (r_cyc != '1)) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if ((w_state_next == StDone) && (r_state != StDone)) begin
                if (r_state == StIdle) begin
                    r_perf <= 32'd1;
                end else begin
                    r_perf <= (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;
                end
            end
        end
    end

    assign bus.o_perf_cycles = r_perf;
`else
    assign bus.o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
module tb_systolic_seq;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    systolic_seq_if #(.N(8), .KMAX(256)) u_if ();

    systolic_seq #(.N(8), .KMAX(256), .CLOAD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pexp(input int v);
`ifdef SEQ_PERF_CNT_EN
        return 32'(v);
`else
        return (v > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int t);
        chk("rst_busy", t, 32'(u_if.o_busy), 0);
        chk("rst_done", t, 32'(u_if.o_done), 0);
        chk("rst_we", t, 32'(u_if.o_we), 0);
        chk("rst_en", t, 32'(u_if.o_en), 0);
        chk("rst_cm", t, 32'(u_if.o_cm), 0);
        chk("rst_out_valid", t, 32'(u_if.o_out_valid), 0);
        chk("rst_c_ready", t, 32'(u_if.o_c_ready), 0);
        chk("rst_out_row", t, 32'(u_if.o_out_row), 0);
        chk("rst_ctype", t, 32'(u_if.o_compute_type_out), 0);
        chk("rst_perf", t, u_if.o_perf_cycles, 0);
    endtask

    // Start a command at cycle 0 and check every cycle through done_c+1 against the
    // hand-derived phase boundaries passed in.
    task automatic run_cmd(input int k, input logic [3:0] ct, input int stall, input bit tog,
                           input int pulse_c, input int we_lo, input int we_hi,
                           input int en_lo, input int en_hi, input int cm_c,
                           input int done_c, input logic [31:0] perf_exp);
        int ndone;
        int row;
        ndone = 0;
        @(posedge clk); #1;
        u_if.i_start_valid  = 1'b1;
        u_if.i_k_len        = 9'(k);
        u_if.i_compute_type = ct;
        u_if.i_c_valid      = (stall == 0);
        u_if.i_out_ready    = 1'b1;
        @(negedge clk);
        chk("start_ready_c0", 0, 32'(u_if.o_start_ready), 1);
        chk("busy_c0", 0, 32'(u_if.o_busy), 0);
        for (int t = 1; t <= done_c + 1; t++) begin
            @(posedge clk); #1;
            if (t == pulse_c) begin
                u_if.i_start_valid  = 1'b1;
                u_if.i_k_len        = 9'd5;
                u_if.i_compute_type = ~ct;
            end else begin
                u_if.i_start_valid  = 1'b0;
            end
            u_if.i_c_valid   = (t > stall);
            u_if.i_out_ready = (tog && t >= cm_c) ? (((t - cm_c) % 3) == 0) : 1'b1;
            @(negedge clk);
            if (u_if.o_done === 1'b1) ndone++;
            if (t >= cm_c && t < done_c) row = tog ? (t - cm_c + 2) / 3 : (t - cm_c);
            else row = 0;
            chk("we", t, 32'(u_if.o_we), 32'(t >= we_lo && t <= we_hi));
            chk("c_ready", t, 32'(u_if.o_c_ready), 32'(t >= 1 && t <= we_hi));
            chk("en", t, 32'(u_if.o_en), 32'(t >= en_lo && t <= en_hi));
            chk("cm", t, 32'(u_if.o_cm), 32'(t == cm_c));
            chk("out_valid", t, 32'(u_if.o_out_valid), 32'(t >= cm_c && t < done_c));
            chk("out_row", t, 32'(u_if.o_out_row), 32'(row));
            chk("done", t, 32'(u_if.o_done), 32'(t == done_c));
            chk("busy", t, 32'(u_if.o_busy), 32'(t <= done_c));
            chk("start_ready", t, 32'(u_if.o_start_ready), 32'(t > done_c));
            chk("ctype_out", t, 32'(u_if.o_compute_type_out), 32'(ct));
            if (t == done_c + 1) chk("perf_cycles", t, u_if.o_perf_cycles, perf_exp);
        end
        chk("done_count", done_c, 32'(ndone), 1);
    endtask

    initial begin
        rst                 = 1'b1;
        u_if.i_start_valid  = 1'b0;
        u_if.i_k_len        = '0;
        u_if.i_compute_type = '0;
        u_if.i_c_valid      = 1'b0;
        u_if.i_out_ready    = 1'b0;

        // Reset cycle: start_ready held low, everything else at reset values.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_start_ready", 0, 32'(u_if.o_start_ready), 0);
        chk_reset_outputs(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_start_ready", 0, 32'(u_if.o_start_ready), 1);

        // Nominal: k=16, we 1-4, en 5-20, cm 36, rows 36-43, done 44.
        run_cmd(16, 4'h5, 0, 1'b0, -1, 1, 4, 5, 20, 36, 44, pexp(44));
        // c_valid low for cycles 1-3: we 4-7, FEED from 8.
        run_cmd(2, 4'hA, 3, 1'b0, -1, 4, 7, 8, 9, 25, 33, pexp(33));
        // out_ready 1,0,0,1,... in DRAIN: rows accepted on 21,24,...,42, done 43.
        run_cmd(1, 4'hC, 0, 1'b1, -1, 1, 4, 5, 5, 21, 43, pexp(43));
        // k_len = 0: done on cycle 1, idle on cycle 2, no we/en/cm.
        run_cmd(0, 4'h7, 0, 1'b0, -1, 1, 0, 1, 0, -1, 1, pexp(1));
        // start_valid pulsed in FEED (cycle 7) is ignored.
        run_cmd(8, 4'h3, 0, 1'b0, 7, 1, 4, 5, 12, 28, 36, pexp(36));

        // Reset in FLUSH (k=2: FLUSH spans cycles 7-21), asserted during cycle 10.
        @(posedge clk); #1;
        u_if.i_start_valid  = 1'b1;
        u_if.i_k_len        = 9'd2;
        u_if.i_compute_type = 4'h6;
        u_if.i_c_valid      = 1'b1;
        u_if.i_out_ready    = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk); #1;
            u_if.i_start_valid = 1'b0;
            if (t == 10) rst = 1'b1;
            @(negedge clk);
            if (t == 8) begin
                chk("flush_en", t, 32'(u_if.o_en), 0);
                chk("flush_busy", t, 32'(u_if.o_busy), 1);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_start_ready", 11, 32'(u_if.o_start_ready), 1);
        chk_reset_outputs(11);
        for (int t = 12; t <= 14; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_no_done", t, 32'(u_if.o_done), 0);
            chk("abort_idle", t, 32'(u_if.o_busy), 0);
        end
        run_cmd(16, 4'hB, 0, 1'b0, -1, 1, 4, 5, 20, 36, 44, pexp(44));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
